// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Main control unit for a multicycle MIPS core. Sequences a shared datapath
// (single memory port, single ALU, register file, PC) through fetch, decode and
// per-class execute states. It decodes opcode/funct, stalls on memory through a
// ready handshake, traps illegal instructions and counts retired instructions.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_opcode       instr[31:26] from the instruction register
//   i_funct        instr[5:0] from the instruction register
//   i_zero         ALU zero flag (branch condition)
//   i_mem_ready    memory completes the current access this cycle
//   o_iord         memory address select: 0=PC, 1=ALUOut
//   o_mem_write    memory write request
//   o_ir_write     instruction register load
//   o_reg_dst      register write address: 1=rd, 0=rt
//   o_mem_to_reg   register write data: 1=data register, 0=ALUOut
//   o_reg_write    register file write enable
//   o_alu_src_a    ALU A: 0=PC, 1=register A
//   o_alu_src_b    ALU B: 00=B, 01=4, 10=signImm, 11=signImm<<2
//   o_alu_control  010 add, 110 sub, 000 and, 001 or, 111 slt
//   o_pc_src       PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   o_pc_en        PC load enable
//   o_illegal      illegal-instruction trap indicator
//   o_state        current state encoding (debug)
//   o_retired      retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_iord,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [2:0]       o_alu_control,
  output logic [1:0]       o_pc_src,
  output logic             o_pc_en,
  output logic             o_illegal,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_retired;

  // Raw (pre reset-gating) control outputs from the state decoder.
  logic       w_iord;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_control;
  logic [1:0] w_pc_src;
  logic       w_pc_en;
  logic       w_illegal;
  logic       w_retire;

  // R-type funct decode
  logic       w_funct_valid;
  logic [2:0] w_funct_alu;

  always_comb begin
    w_funct_valid = 1'b1;
    w_funct_alu   = ALU_ADD;
    case (i_funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_valid = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_next  = r_state;
    w_iord        = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = ALU_ADD;
    w_pc_src      = 2'b00;
    w_pc_en       = 1'b0;
    w_illegal     = 1'b0;
    w_retire      = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 is written back the same cycle the instruction is captured.
        w_alu_src_b = 2'b01;
        w_ir_write  = i_mem_ready;
        w_pc_en     = i_mem_ready;
        if (i_mem_ready) w_state_next = S_DECODE;
      end

      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        w_alu_src_b = 2'b11;
        case (i_opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_R:         w_state_next = w_funct_valid ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_ADDIEX;
          OP_J:         w_state_next = S_JUMP;
          default:      w_state_next = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        // Only LW/SW reach here; anything else means the IR changed under us.
        if (i_opcode == OP_LW)      w_state_next = S_MEMRD;
        else if (i_opcode == OP_SW) w_state_next = S_MEMWR;
        else                        w_state_next = S_ILLEGAL;
      end

      S_MEMRD: begin
        w_iord = 1'b1;
        if (i_mem_ready) w_state_next = S_MEMWB;
      end

      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_EXECUTE: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'b00;
        w_alu_control = w_funct_alu;
        w_state_next  = S_ALUWB;
      end

      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = 2'b01;
        w_pc_en       = i_zero;
        w_retire      = 1'b1;
        w_state_next  = S_FETCH;
      end

      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_state_next = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_en      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_ILLEGAL: begin
        // Trap is sticky; only reset leaves this state.
        w_illegal    = 1'b1;
        w_state_next = S_ILLEGAL;
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Write/load enables are gated by the reset input itself so they drop the
  // moment reset is asserted, independent of any clock edge.
  assign o_ir_write    = w_ir_write  & i_rst_n;
  assign o_pc_en       = w_pc_en     & i_rst_n;
  assign o_reg_write   = w_reg_write & i_rst_n;
  assign o_mem_write   = w_mem_write & i_rst_n;

  assign o_iord        = w_iord;
  assign o_reg_dst     = w_reg_dst;
  assign o_mem_to_reg  = w_mem_to_reg;
  assign o_alu_src_a   = w_alu_src_a;
  assign o_alu_src_b   = w_alu_src_b;
  assign o_alu_control = w_alu_control;
  assign o_pc_src      = w_pc_src;
  assign o_illegal     = w_illegal;
  assign o_state       = r_state;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// Directed testbench for multicycle_control_fsm. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// A second instance with CNT_W=4 exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        ready;

  logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, pc_en, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic [31:0] retired;

  // Narrow-counter instance
  logic        rst4_n;
  logic        iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4;
  logic        alu_src_a4, pc_en4, illegal4;
  logic [1:0]  alu_src_b4, pc_src4;
  logic [2:0]  alu_control4;
  logic [3:0]  state4;
  logic [3:0]  retired4;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct(funct),
    .i_zero(zero), .i_mem_ready(ready),
    .o_iord(iord), .o_mem_write(mem_write), .o_ir_write(ir_write),
    .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_control(alu_control), .o_pc_src(pc_src), .o_pc_en(pc_en),
    .o_illegal(illegal), .o_state(state), .o_retired(retired)
  );

  multicycle_control_fsm #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_opcode(6'b000010), .i_funct(6'b000000),
    .i_zero(1'b0), .i_mem_ready(1'b1),
    .o_iord(iord4), .o_mem_write(mem_write4), .o_ir_write(ir_write4),
    .o_reg_dst(reg_dst4), .o_mem_to_reg(mem_to_reg4), .o_reg_write(reg_write4),
    .o_alu_src_a(alu_src_a4), .o_alu_src_b(alu_src_b4),
    .o_alu_control(alu_control4), .o_pc_src(pc_src4), .o_pc_en(pc_en4),
    .o_illegal(illegal4), .o_state(state4), .o_retired(retired4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the next falling edge and check the state there.
  task automatic expect_state(input string tag, input logic [3:0] st);
    @(negedge clk);
    check({tag, ".state"}, 32'(state), 32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    ready  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.state",     32'(state),     32'd0);
    check("rst.retired",   retired,        32'd0);
    check("rst.ir_write",  32'(ir_write),  32'd0);
    check("rst.pc_en",     32'(pc_en),     32'd0);
    check("rst.mem_write", 32'(mem_write), 32'd0);
    nxt();
    rst_n = 1'b1;
    $display("reset released");

    // ---------------- LW, ready always high ----------------
    opcode = 6'b100011;
    expect_state("lw0", 4'd0);
    check("lw0.retired",  retired,          32'(exp_ret));
    check("lw0.ir_write", 32'(ir_write),    32'd1);
    check("lw0.pc_en",    32'(pc_en),       32'd1);
    check("lw0.srcb",     32'(alu_src_b),   32'd1);
    check("lw0.alu",      32'(alu_control), 32'b010);
    nxt();
    expect_state("lw1", 4'd1);
    check("lw1.srcb",     32'(alu_src_b),   32'd3);
    check("lw1.regwr",    32'(reg_write),   32'd0);
    nxt();
    expect_state("lw2", 4'd2);
    check("lw2.srca",     32'(alu_src_a),   32'd1);
    check("lw2.srcb",     32'(alu_src_b),   32'd2);
    nxt();
    expect_state("lw3", 4'd3);
    check("lw3.iord",     32'(iord),        32'd1);
    check("lw3.regwr",    32'(reg_write),   32'd0);
    check("lw3.m2r",      32'(mem_to_reg),  32'd0);
    nxt();
    expect_state("lw4", 4'd4);
    check("lw4.regwr",    32'(reg_write),   32'd1);
    check("lw4.m2r",      32'(mem_to_reg),  32'd1);
    check("lw4.retired",  retired,          32'(exp_ret));
    nxt();
    exp_ret++;
    $display("LW  done, expected retired=%0d", exp_ret);

    // ---------------- R-type sub ----------------
    opcode = 6'b000000;
    funct  = 6'b100010;
    expect_state("r0", 4'd0);
    check("r0.retired",   retired,          32'(exp_ret));
    nxt();
    expect_state("r1", 4'd1);
    nxt();
    expect_state("r6", 4'd6);
    check("r6.alu",       32'(alu_control), 32'b110);
    check("r6.srca",      32'(alu_src_a),   32'd1);
    check("r6.srcb",      32'(alu_src_b),   32'd0);
    check("r6.regwr",     32'(reg_write),   32'd0);
    nxt();
    expect_state("r7", 4'd7);
    check("r7.regdst",    32'(reg_dst),     32'd1);
    check("r7.regwr",     32'(reg_write),   32'd1);
    check("r7.alu",       32'(alu_control), 32'b010);
    nxt();
    exp_ret++;
    $display("SUB done, expected retired=%0d", exp_ret);

    // ---------------- BEQ taken, then not taken ----------------
    for (int k = 0; k < 2; k++) begin
      opcode = 6'b000100;
      zero   = (k == 0);
      expect_state("beq0", 4'd0);
      check("beq0.retired", retired, 32'(exp_ret));
      nxt();
      expect_state("beq1", 4'd1);
      nxt();
      expect_state("beq8", 4'd8);
      check("beq8.pc_en",   32'(pc_en),       (k == 0) ? 32'd1 : 32'd0);
      check("beq8.pc_src",  32'(pc_src),      32'd1);
      check("beq8.alu",     32'(alu_control), 32'b110);
      nxt();
      exp_ret++;
      $display("BEQ done (zero=%0d), expected retired=%0d", zero, exp_ret);
    end
    zero = 1'b0;

    // ---------------- ADDI ----------------
    opcode = 6'b001000;
    expect_state("addi0", 4'd0);
    check("addi0.retired", retired, 32'(exp_ret));
    nxt();
    expect_state("addi1", 4'd1);
    nxt();
    expect_state("addi9", 4'd9);
    check("addi9.srcb",   32'(alu_src_b),  32'd2);
    check("addi9.regwr",  32'(reg_write),  32'd0);
    nxt();
    expect_state("addi10", 4'd10);
    check("addi10.regwr", 32'(reg_write),  32'd1);
    check("addi10.regdst",32'(reg_dst),    32'd0);
    nxt();
    exp_ret++;
    $display("ADDI done, expected retired=%0d", exp_ret);

    // ---------------- SW with memory stalls ----------------
    opcode = 6'b101011;
    ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_state("swf", 4'd0);
      check("swf.ir_write", 32'(ir_write), 32'd0);
      check("swf.pc_en",    32'(pc_en),    32'd0);
      nxt();
    end
    ready = 1'b1;
    expect_state("swf", 4'd0);
    check("swf.ir_write_rdy", 32'(ir_write), 32'd1);
    check("swf.retired",      retired,       32'(exp_ret));
    nxt();
    expect_state("sw1", 4'd1);
    nxt();
    expect_state("sw2", 4'd2);
    nxt();
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expect_state("sw5", 4'd5);
      check("sw5.memwr",   32'(mem_write), 32'd1);
      check("sw5.iord",    32'(iord),      32'd1);
      check("sw5.retired", retired,        32'(exp_ret));
      nxt();
    end
    ready = 1'b1;
    expect_state("sw5r", 4'd5);
    check("sw5r.memwr",    32'(mem_write), 32'd1);
    check("sw5r.iord",     32'(iord),      32'd1);
    nxt();
    exp_ret++;
    $display("SW  done (stalled), expected retired=%0d", exp_ret);

    // ---------------- J ----------------
    opcode = 6'b000010;
    expect_state("j0", 4'd0);
    check("j0.retired", retired, 32'(exp_ret));
    check("j0.memwr",   32'(mem_write), 32'd0);
    nxt();
    expect_state("j1", 4'd1);
    nxt();
    expect_state("j11", 4'd11);
    check("j11.pc_en",  32'(pc_en),  32'd1);
    check("j11.pc_src", 32'(pc_src), 32'd2);
    nxt();
    exp_ret++;
    $display("J   done, expected retired=%0d", exp_ret);

    // ---------------- illegal opcode ----------------
    opcode = 6'b111111;
    expect_state("ill0", 4'd0);
    check("ill0.retired", retired, 32'(exp_ret));
    nxt();
    expect_state("ill1", 4'd1);
    nxt();
    for (int k = 0; k < 10; k++) begin
      expect_state("ill15", 4'd15);
      check("ill15.illegal", 32'(illegal), 32'd1);
      check("ill15.enables", 32'({ir_write, pc_en, reg_write, mem_write}), 32'd0);
      nxt();
    end
    check("ill.retired_hold", retired, 32'(exp_ret));
    rst_n = 1'b0;
    #2;
    check("illrst.state",   32'(state),   32'd0);
    check("illrst.illegal", 32'(illegal), 32'd0);
    check("illrst.retired", retired,      32'd0);
    exp_ret = 0;
    nxt();
    rst_n = 1'b1;
    $display("ILLEGAL trapped and cleared by reset");

    // ---------------- async reset mid-MEMWR ----------------
    opcode = 6'b101011;
    expect_state("ab0", 4'd0);
    nxt();
    expect_state("ab1", 4'd1);
    nxt();
    expect_state("ab2", 4'd2);
    nxt();
    ready = 1'b0;
    expect_state("ab5", 4'd5);
    check("ab5.memwr", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abrst.memwr",   32'(mem_write), 32'd0);
    check("abrst.state",   32'(state),     32'd0);
    check("abrst.retired", retired,        32'd0);
    ready = 1'b1;
    nxt();
    check("abrst.ir_write", 32'(ir_write), 32'd0);
    rst_n = 1'b1;
    $display("SW  aborted by reset, expected retired=%0d", exp_ret);

    // ---------------- J after abort ----------------
    opcode = 6'b000010;
    expect_state("ja0", 4'd0);
    check("ja0.retired", retired, 32'd0);
    nxt();
    expect_state("ja1", 4'd1);
    nxt();
    expect_state("ja11", 4'd11);
    nxt();
    exp_ret++;
    expect_state("ja_end", 4'd0);
    check("ja_end.retired", retired, 32'(exp_ret));
    $display("J   done, expected retired=%0d", exp_ret);

    // ---------------- 4-bit counter wrap, 16 jumps ----------------
    @(posedge clk);
    #1;
    rst4_n = 1'b1;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("wrap.retired15", 32'(retired4), 32'd15);
    check("wrap.state",     32'(state4),   32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap.retired0",  32'(retired4), 32'd0);
    $display("16 J on CNT_W=4, expected retired wrap to 0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control unit for the multicycle MIPS core. It is a state machine that sequences the shared datapath:
- one memory port for instruction and data (IorD);
- one ALU used for PC+4, branch target and execute;
- the register file and PC enables.

It decodes opcode and funct, waits on memory through a ready handshake, traps illegal instructions and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter o_retired (wraps modulo 2^CNT_W)

Ports:
i_clk  in  1  system clock, all state updates on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_opcode  in  6  instr[31:26] from instruction register
i_funct  in  6  instr[5:0] from instruction register
i_zero  in  1  ALU zero flag
i_mem_ready  in  1  memory completes the current access this cycle
o_iord  out  1  0=PC addresses memory, 1=ALUOut addresses memory
o_mem_write  out  1  memory write request
o_ir_write  out  1  instruction register load
o_reg_dst  out  1  1=rd, 0=rt write address
o_mem_to_reg  out  1  1=data register, 0=ALUOut to WD3
o_reg_write  out  1  register file write enable
o_alu_src_a  out  1  0=PC, 1=register A
o_alu_src_b  out  2  00=B, 01=const 4, 10=signImm, 11=signImm<<2
o_alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
o_pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
o_pc_en  out  1  PC load enable
o_illegal  out  1  trap indicator
o_state  out  4  current state encoding (debug)
o_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=FETCH, o_retired=0.
  - While in reset, o_ir_write, o_pc_en, o_reg_write and o_mem_write are forced to 0.
- Outputs are combinational from state, with Mealy gating by i_mem_ready and i_zero where noted.
  - Outputs not listed for a state are 0; o_alu_control defaults to 010.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- Funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
- State encodings and actions:
  - FETCH 0: alu_src_b=01, add.
    - o_ir_write=o_pc_en=i_mem_ready.
    - ready=1 → DECODE; else stay.
  - DECODE 1: alu_src_b=11, add (branch target into ALUOut). Next state:
    - LW/SW → MEMADR.
    - R with valid funct → EXECUTE.
    - BEQ → BRANCH.
    - ADDI → ADDIEX.
    - J → JUMP.
    - Any other opcode, or R with unlisted funct → ILLEGAL.
  - MEMADR 2: alu_src_a=1, alu_src_b=10, add. LW → MEMRD, SW → MEMWR.
  - MEMRD 3: iord=1, held until ready=1 → MEMWB.
  - MEMWB 4: mem_to_reg=1, reg_write=1 → FETCH.
  - MEMWR 5: iord=1, mem_write=1, held until ready=1 → FETCH.
  - EXECUTE 6: alu_src_a=1, alu_src_b=00, alu_control per funct → ALUWB.
  - ALUWB 7: reg_dst=1, reg_write=1 → FETCH.
  - BRANCH 8: alu_src_a=1, sub, pc_src=01, o_pc_en=i_zero → FETCH.
  - ADDIEX 9: alu_src_a=1, alu_src_b=10, add → ADDIWB.
  - ADDIWB 10: reg_write=1 → FETCH.
  - JUMP 11: pc_src=10, o_pc_en=1 → FETCH.
  - ILLEGAL 15: o_illegal=1; no enables asserted; stays until reset.
  - Unused encodings → FETCH next cycle, no enables.
- o_retired increments by 1 on every transition into FETCH from a completing state:
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP;
  - MEMWR with ready=1.
  - Wraps to 0 after all-ones.
- Latency with ready=1 every cycle:
  - LW 5 cycles; SW 4; R 4; ADDI 4; BEQ 3; J 3.
- Each cycle with ready=0 adds one cycle in FETCH, MEMRD or MEMWR.
- Reset mid-instruction aborts it: no write is issued after reset is asserted, and the counter does not increment.

Test Plan:
1. LW (100011), ready=1 always → o_state 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4; o_retired 0→1.
2. R-type funct 100010 → states 0,1,6,7,0; o_alu_control=110 in state 6; reg_dst=1 and reg_write=1 in state 7.
3. BEQ twice:
   - i_zero=1 → o_pc_en=1 with pc_src=01 in state 8.
   - i_zero=0 → o_pc_en=0.
   - Both retire (count +2).
4. SW with ready low 3 cycles in FETCH and 2 cycles in MEMWR:
   - FETCH held with ir_write=0 while ready=0.
   - MEMWR holds mem_write=1 and iord=1 for 3 cycles; retire on the ready cycle only.
5. Opcode 111111 → DECODE → state 15, o_illegal=1 for ≥10 cycles with no enables; after i_rst_n pulse, state=0, o_illegal=0, o_retired=0.
6. Assert i_rst_n=0 asynchronously mid-MEMWR → o_mem_write drops without waiting for a clock edge; state=0; no retire.
   - Separately, with CNT_W=4, 16 J instructions → o_retired wraps to 0.
